// File: rtl/seg_adder_seq.sv
// Multi-cycle segmented adder/subtractor: one SEG-bit adder reused NSEG times,
// low segment first, with the inter-segment carry held in a register.
module seg_adder_seq #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SEG-1:0]  seg_a;
  logic [SEG-1:0]  seg_b;
  logic [SEG-1:0]  seg_s;
  logic [SEG:0]    seg_full;
  logic            seg_c;
  logic            seg_msb_cin;
  logic            last_seg;

  assign seg_a       = a_q[idx*SEG +: SEG];
  assign seg_b       = b_q[idx*SEG +: SEG];
  assign seg_full    = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry};
  assign seg_s       = seg_full[SEG-1:0];
  assign seg_c       = seg_full[SEG];
  // Carry into the segment MSB recovered from the MSB sum bit and its operands.
  assign seg_msb_cin = seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_s[SEG-1];
  assign last_seg    = (idx == IDXW'(NSEG - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_seg)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Index wraps to zero on the last segment so it never addresses past WIDTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[idx*SEG +: SEG] <= seg_s;
          carry <= seg_c;
          if (last_seg) begin
            idx  <= '0;
            cout <= seg_c;
            ovf  <= seg_msb_cin ^ seg_c;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_adder_seq.sv
// Scoreboard bench for seg_adder_seq: 32/16 main instance plus a 24/8 instance.
module tb_seg_adder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, cout2, ovf2;
  logic [23:0] a2, b2, sum2;

  seg_adder_seq #(.WIDTH(32), .SEG(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seg_adder_seq #(.WIDTH(24), .SEG(8)) dut24 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(1'b0), .cin(1'b0), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   accept_cycle = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: full-width add, overflow from operand/result sign bits.
  function automatic logic [33:0] model(input logic [31:0] va, input logic [31:0] vb,
                                        input logic vs, input logic vc);
    logic [31:0] bx;
    logic [32:0] full;
    logic        v;
    bx   = vs ? ~vb : vb;
    full = {1'b0, va} + {1'b0, bx} + {32'd0, vc};
    v    = (va[31] == bx[31]) && (full[31] != va[31]);
    return {v, full[32], full[31:0]};
  endfunction

  always @(negedge clk) begin
    if (resetn && out_valid && !prev_ov)
      checkOutput("latency", 64'(cycle - accept_cycle), 64'd2);
    if (resetn && out_valid && out_ready) begin
      checkOutput("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sum", 64'(sum), 64'(e.sum));
        checkOutput("cout", 64'(cout), 64'(e.cout));
        checkOutput("ovf", 64'(ovf), 64'(e.ovf));
      end
    end
    prev_ov = out_valid;
  end

  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               input logic vs, input logic vc,
                               input logic [31:0] es, input logic ec, input logic eo,
                               input bit push);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", 64'(in_ready), 64'd1);
    a = va; b = vb; sub = vs; cin = vc; in_valid = 1'b1;
    accept_cycle = cycle + 1;
    if (push) begin
      e.sum = es; e.cout = ec; e.ovf = eo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [33:0] r;
    logic [31:0] ra, rb;
    logic        rs, rc;
    int          n;

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst24_sum", 64'(sum2), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    waitDrain();

    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 32'h8000FFFF; rb = 32'h8000FFFF; rs = 1'b0; rc = 1'b1; end
      r = model(ra, rb, rs, rc);
      applyStimulus(ra, rb, rs, rc, r[31:0], r[32], r[33], 1'b1);
    end
    waitDrain();

    // Backpressure: result must hold while new requests are ignored.
    out_ready = 1'b0;
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_valid_wait", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_sum", 64'(sum), 64'h2345678A);
      checkOutput("bp_cout", 64'(cout), 64'd0);
      checkOutput("bp_ovf", 64'(ovf), 64'd0);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);
    checkOutput("bp_out_valid_after", 64'(out_valid), 64'd0);
    checkOutput("bp_drained", 64'(sb.size()), 64'd0);

    // Abort during the first segment: no result may appear.
    applyStimulus(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_valid", 64'(out_valid), 64'd0);
    end
    applyStimulus(32'h0001FFFF, 32'h0000FFFF, 1'b0, 1'b1, 32'h0002FFFF, 1'b0, 1'b0, 1'b1);
    waitDrain();

    // 24/8 instance: three segments, carry through two segment boundaries.
    a2 = 24'h00FFFF; b2 = 24'h000001; in_valid2 = 1'b1;
    checkOutput("w24_in_ready", 64'(in_ready2), 64'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0; a2 = 24'h123456; b2 = 24'h654321;
    n = 0;
    while (!out_valid2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w24_latency", 64'(n), 64'd3);
    checkOutput("w24_sum", 64'(sum2), 64'h010000);
    checkOutput("w24_cout", 64'(cout2), 64'd0);
    checkOutput("w24_ovf", 64'(ovf2), 64'd0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    checkOutput("w24_in_ready_after", 64'(in_ready2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_adder_seq.md
# seg_adder_seq

Parametrised, multi-cycle segmented adder/subtractor. It adds two `WIDTH`-bit operands one `SEG`-bit segment per clock, low segment first, and ripples the carry between segments through a register. It adds add/subtract mode, carry-in, carry-out, signed overflow and valid/ready handshakes on both sides. It is the area-lean replacement for the fixed 32-bit two-segment combinational adder: one `SEG`-bit adder is reused `WIDTH/SEG` times.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.
- `SEG`, default 16: segment width. `WIDTH % SEG` must be 0 and `SEG >= 1`. `NSEG = WIDTH/SEG`, which is at least 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept an operand; equals (state == IDLE).
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `sub`  in  1  0 = A+B+cin; 1 = A+~B+cin, so cin=1 gives A−B.
- `cin`  in  1  carry-in to segment 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready`, latch `a`, `b ^ {WIDTH{sub}}`, and `carry = cin`. Clear segment index `idx = 0`. Go to RUN.
- RUN, each cycle:
  - `{c, s} = a_q[idx*SEG +: SEG] + b_q[idx*SEG +: SEG] + carry`.
  - Write `s` into `sum[idx*SEG +: SEG]`; `carry <= c`; `idx <= idx+1`.
  - When `idx == NSEG-1`: set `cout = c` and `ovf` = carry into bit `SEG-1` of this segment XOR `c`; go to DONE.
  - Segment arithmetic is `SEG+1` bits wide; no other carry path exists.
- DONE:
  - `out_valid=1`.
  - `sum`, `cout` and `ovf` are held stable until `out_valid & out_ready`, then go to IDLE.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Inputs `a`, `b`, `sub` and `cin` are sampled only at the accept edge. Changes afterwards do not affect the operation in flight.
- `sum`, `cout` and `ovf` are meaningful only while `out_valid=1`. They are not cleared on handshake. `sum` segments are overwritten progressively during the next RUN.
- Reset (`resetn=0` at a rising edge):
  - state = IDLE, `idx=0`, carry = 0.
  - `out_valid=0`, `sum=0`, `cout=0`, `ovf=0`.
  - `in_ready` reads 1 after the reset edge.
- Reset in RUN or DONE aborts the operation. No `out_valid` pulse is produced for it.
- Width rule: no sign or zero extension. `sum` is exactly `WIDTH` bits, modulo 2^WIDTH.

## Timing
- Accept edge E0 is the edge where `in_valid & in_ready` is high.
- RUN occupies edges E1..E_NSEG. `out_valid` rises after edge E_NSEG, giving a latency of `NSEG` cycles from the accept edge.
- Result handshake at edge Eh: state returns to IDLE and `in_ready=1` in the following cycle. The next accept is possible at edge Eh+1 at the earliest.
- Peak throughput is one operation per `NSEG+2` cycles.
- With `NSEG=1`, RUN lasts exactly one cycle; the behaviour is otherwise identical.
- `in_ready` and `out_valid` are functions of registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
Defaults `WIDTH=32`, `SEG=16` unless stated.
- Cross-segment carry: `a=0x0000FFFF`, `b=0x00000001`, `sub=0`, `cin=0` -> `sum=0x00010000`, `cout=0`, `ovf=0`. `out_valid` rises exactly 2 cycles after the accept edge.
- Full wrap and carry-out: `a=0xFFFFFFFF`, `b=0x00000001` -> `sum=0x00000000`, `cout=1`, `ovf=0`.
- Signed overflow:
  - `a=0x7FFFFFFF`, `b=1` -> `sum=0x80000000`, `cout=0`, `ovf=1`.
  - Subtract, `a=0x80000000`, `b=1`, `sub=1`, `cin=1` -> `sum=0x7FFFFFFF`, `cout=1`, `ovf=1`.
- Subtract with borrow: `a=5`, `b=7`, `sub=1`, `cin=1` -> `sum=0xFFFFFFFE`, `cout=0`, `ovf=0`.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE -> `out_valid`, `sum`, `cout` and `ovf` stay stable; `in_ready=0`; new `in_valid` is ignored. Raise `out_ready` -> `in_ready=1` the next cycle.
- Reset mid-RUN, plus an alternate instance:
  - Drop `resetn` for one edge during the first segment -> `out_valid` never pulses; `in_ready=1` after reset; a fresh operation completes correctly.
  - Instance `WIDTH=24`, `SEG=8`: `a=0x00FFFF`, `b=1` -> `sum=0x010000` with a latency of 3 cycles.
